// File: rtl/regfile_write_arbiter_if.sv
// Write-arbiter bundle: ALU and memory writeback handshakes, the register-file write port
// and the decode-stage hazard checks.
`ifndef WordWidth
`define WordWidth 32
`endif
`ifndef Def_RegisterSelectWidth
`define Def_RegisterSelectWidth 4
`endif

interface regfile_write_arbiter_if #(
    parameter int WordWidth = `WordWidth,
    parameter int SelWidth  = `Def_RegisterSelectWidth
);
    logic                 in_AluWriteRequest;
    logic [SelWidth-1:0]  in_AluWriteRegisterNumber;
    logic [WordWidth-1:0] in_AluWriteBus;
    logic                 out_AluWriteGrant;

    logic                 in_MemWriteRequest;
    logic [SelWidth-1:0]  in_MemWriteRegisterNumber;
    logic [WordWidth-1:0] in_MemWriteBus;
    logic                 out_MemWriteGrant;

    logic                 out_WriteEnable;
    logic [SelWidth-1:0]  out_WriteRegisterNumber;
    logic [WordWidth-1:0] out_WriteBus;

    logic [SelWidth-1:0]  in_LeftCheckRegisterNumber;
    logic [SelWidth-1:0]  in_RightCheckRegisterNumber;
    logic                 out_LeftReadHazard;
    logic                 out_RightReadHazard;

    modport master (
        output in_AluWriteRequest, in_AluWriteRegisterNumber, in_AluWriteBus,
        output in_MemWriteRequest, in_MemWriteRegisterNumber, in_MemWriteBus,
        output in_LeftCheckRegisterNumber, in_RightCheckRegisterNumber,
        input  out_AluWriteGrant, out_MemWriteGrant,
        input  out_WriteEnable, out_WriteRegisterNumber, out_WriteBus,
        input  out_LeftReadHazard, out_RightReadHazard
    );

    modport slave (
        input  in_AluWriteRequest, in_AluWriteRegisterNumber, in_AluWriteBus,
        input  in_MemWriteRequest, in_MemWriteRegisterNumber, in_MemWriteBus,
        input  in_LeftCheckRegisterNumber, in_RightCheckRegisterNumber,
        output out_AluWriteGrant, out_MemWriteGrant,
        output out_WriteEnable, out_WriteRegisterNumber, out_WriteBus,
        output out_LeftReadHazard, out_RightReadHazard
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and memory writeback via one-entry buffers.
// Define REGARB_ROUNDROBIN_EN for round-robin conflicts; default build gives MEM fixed priority.
`ifndef WordWidth
`define WordWidth 32
`endif
`ifndef Def_RegisterSelectWidth
`define Def_RegisterSelectWidth 4
`endif

module regfile_write_arbiter #(
    parameter int WordWidth = `WordWidth,
    parameter int SelWidth  = `Def_RegisterSelectWidth
) (
    input logic                   clock,
    input logic                   reset,
    regfile_write_arbiter_if.slave wrIf
);

    logic                 aluVld_p0, memVld_p0;
    logic [SelWidth-1:0]  aluReg_p0, memReg_p0;
    logic [WordWidth-1:0] aluData_p0, memData_p0;
    logic                 memOlder_p0;
`ifdef REGARB_ROUNDROBIN_EN
    logic                 lastMem_p0;
`endif

    logic                 vld_p1;
    logic [SelWidth-1:0]  wrReg_p1;
    logic [WordWidth-1:0] wrData_p1;

    logic sameReg, conflict, conflictPickMem;
    logic selAlu, selMem, grantAlu, grantMem, loadAlu, loadMem;

    function automatic logic pendingMatch(
        input logic                aVld, input logic [SelWidth-1:0] aReg,
        input logic                mVld, input logic [SelWidth-1:0] mReg,
        input logic                pVld, input logic [SelWidth-1:0] pReg,
        input logic [SelWidth-1:0] chk
    );
        return (aVld && (aReg == chk)) || (mVld && (mReg == chk)) || (pVld && (pReg == chk));
    endfunction

    assign sameReg  = (aluReg_p0 == memReg_p0);
    assign conflict = aluVld_p0 && memVld_p0 && !sameReg;

`ifdef REGARB_ROUNDROBIN_EN
    assign conflictPickMem = !lastMem_p0;
`else
    assign conflictPickMem = 1'b1;
`endif

    always_comb begin
        selAlu = 1'b0;
        selMem = 1'b0;
        if (aluVld_p0 && memVld_p0) begin
            // Same destination must drain in program order; otherwise the policy decides.
            selMem = sameReg ? memOlder_p0 : conflictPickMem;
            selAlu = !selMem;
        end else begin
            selAlu = aluVld_p0;
            selMem = memVld_p0;
        end
    end

    assign grantAlu = reset && (!aluVld_p0 || selAlu);
    assign grantMem = reset && (!memVld_p0 || selMem);
    assign loadAlu  = wrIf.in_AluWriteRequest && grantAlu;
    assign loadMem  = wrIf.in_MemWriteRequest && grantMem;

    // Stage p0: holding buffers, age and round-robin state
    always_ff @(posedge clock) begin
        if (!reset) begin
            aluVld_p0   <= 1'b0;
            memVld_p0   <= 1'b0;
            memOlder_p0 <= 1'b0;
`ifdef REGARB_ROUNDROBIN_EN
            lastMem_p0  <= 1'b0;
`endif
        end else begin
            if (loadAlu)     aluVld_p0 <= 1'b1;
            else if (selAlu) aluVld_p0 <= 1'b0;
            if (loadMem)     memVld_p0 <= 1'b1;
            else if (selMem) memVld_p0 <= 1'b0;

            if (loadAlu && loadMem)                        memOlder_p0 <= 1'b0;
            else if (loadAlu && memVld_p0 && !selMem)      memOlder_p0 <= 1'b1;
            else if (loadMem && aluVld_p0 && !selAlu)      memOlder_p0 <= 1'b0;
`ifdef REGARB_ROUNDROBIN_EN
            if (conflict) lastMem_p0 <= selMem;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (loadAlu) begin
            aluReg_p0  <= wrIf.in_AluWriteRegisterNumber;
            aluData_p0 <= wrIf.in_AluWriteBus;
        end
        if (loadMem) begin
            memReg_p0  <= wrIf.in_MemWriteRegisterNumber;
            memData_p0 <= wrIf.in_MemWriteBus;
        end
    end

    // Stage p1: registered write port
    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_p1    <= 1'b0;
            wrReg_p1  <= '0;
            wrData_p1 <= '0;
        end else begin
            vld_p1 <= selAlu || selMem;
            if (selAlu) begin
                wrReg_p1  <= aluReg_p0;
                wrData_p1 <= aluData_p0;
            end else if (selMem) begin
                wrReg_p1  <= memReg_p0;
                wrData_p1 <= memData_p0;
            end
        end
    end

    assign wrIf.out_AluWriteGrant       = grantAlu;
    assign wrIf.out_MemWriteGrant       = grantMem;
    assign wrIf.out_WriteEnable         = vld_p1;
    assign wrIf.out_WriteRegisterNumber = wrReg_p1;
    assign wrIf.out_WriteBus            = wrData_p1;

    assign wrIf.out_LeftReadHazard  = pendingMatch(aluVld_p0, aluReg_p0, memVld_p0, memReg_p0,
                                                   vld_p1, wrReg_p1, wrIf.in_LeftCheckRegisterNumber);
    assign wrIf.out_RightReadHazard = pendingMatch(aluVld_p0, aluReg_p0, memVld_p0, memReg_p0,
                                                   vld_p1, wrReg_p1, wrIf.in_RightCheckRegisterNumber);

endmodule
